time_clock_counter: RTL and testbench

- Time-of-day counter stage directly downstream of the clock divider.
- Consumes the divider's 100 Hz square wave, which has a period of 1,000,000 i_clk cycles at 100 MHz. Converts each rising edge into a one-cycle tick in the i_clk domain.
- Ticks advance a centisecond/second/minute/hour counter chain.
- Provides run/stop, clear and manual time-set; the outputs feed the display formatter.

---
 rtl/time_clock_counter.sv | 170 +++++++++++++++++
 tb/tb_time_clock_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/time_clock_counter.sv
// time_clock_counter: time-of-day counter fed by the 100 Hz divider output.
// The divided square wave is edge-detected into a one-cycle tick in the i_clk
// domain. Ticks advance a csec/sec/min/hour chain. Run/stop, clear and manual
// set are provided.
//
// Optional build macro: TIME_CLOCK_12H_EN selects a 12-hour clock (12,1..11 with
// a PM flag). When it is undefined the clock runs 0..HOURS_PER_DAY-1 and o_pm is 0.
//
// Ports:
//   i_clk        system clock (100 MHz)
//   i_reset      synchronous active-high reset
//   i_tick_clk   divided square wave; each rising edge is one tick
//   i_run        1 = count ticks, 0 = hold
//   i_clear      synchronous clear of all time fields
//   i_set_en     set mode, counting paused
//   i_set_sel    0 = sec, 1 = min, 2 = hour, 3 = none
//   i_set_inc    debounced button; each rising edge bumps the selected field
//   o_csec       centiseconds 0..TICK_HZ-1
//   o_sec        seconds 0..59
//   o_min        minutes 0..59
//   o_hour       hours
//   o_pm         PM flag (12h build only)
//   o_sec_pulse  one-cycle pulse on each counted seconds advance
module time_clock_counter #(
   parameter int unsigned TICK_HZ       = 100,
   parameter int unsigned HOURS_PER_DAY = 24
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick_clk,
   input  logic       i_run,
   input  logic       i_clear,
   input  logic       i_set_en,
   input  logic [1:0] i_set_sel,
   input  logic       i_set_inc,
   output logic [6:0] o_csec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_pm,
   output logic       o_sec_pulse
);

   localparam logic [6:0] CsecMax = 7'(TICK_HZ - 1);
`ifdef TIME_CLOCK_12H_EN
   localparam logic [4:0] HourRst = 5'd12;
`else
   localparam logic [4:0] HourMax = 5'(HOURS_PER_DAY - 1);
   localparam logic [4:0] HourRst = 5'd0;
`endif

   logic       tick_s1_q, tick_s2_q;
   logic       inc_s1_q, inc_s2_q;
   logic [6:0] csec_q, csec_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic       pm_q, pm_d;
   logic       sec_pulse_q, sec_pulse_d;

   logic       tick, inc, cnt;
   logic [4:0] hour_inc;
   logic       pm_inc;

   assign tick = tick_s1_q & ~tick_s2_q;
   assign inc  = inc_s1_q & ~inc_s2_q;
   assign cnt  = tick & i_run & ~i_set_en;

   // Next hour value, shared by counting carry and set-mode increment.
   always_comb begin
      hour_inc = hour_q + 5'd1;
      pm_inc   = pm_q;
`ifdef TIME_CLOCK_12H_EN
      if (hour_q == 5'd12) begin
         hour_inc = 5'd1;
      end else if (hour_q == 5'd11) begin
         hour_inc = 5'd12;
         pm_inc   = ~pm_q;
      end
`else
      if (hour_q == HourMax) begin
         hour_inc = 5'd0;
      end
`endif
   end

   always_comb begin
      csec_d      = csec_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hour_d      = hour_q;
      pm_d        = pm_q;
      sec_pulse_d = 1'b0;
      if (i_clear) begin
         csec_d = '0;
         sec_d  = '0;
         min_d  = '0;
         hour_d = HourRst;
         pm_d   = 1'b0;
      end else if (i_set_en && inc) begin
         // Set-mode bumps wrap within the field and never carry.
         case (i_set_sel)
            2'd0: begin
               sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
               csec_d = '0;
            end
            2'd1: min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            2'd2: begin
               hour_d = hour_inc;
               pm_d   = pm_inc;
            end
            default: ;
         endcase
      end else if (cnt) begin
         if (csec_q == CsecMax) begin
            csec_d      = '0;
            sec_pulse_d = 1'b1;
            if (sec_q == 6'd59) begin
               sec_d = '0;
               if (min_q == 6'd59) begin
                  min_d  = '0;
                  hour_d = hour_inc;
                  pm_d   = pm_inc;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end else begin
            csec_d = csec_q + 7'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tick_s1_q   <= 1'b0;
         tick_s2_q   <= 1'b0;
         inc_s1_q    <= 1'b0;
         inc_s2_q    <= 1'b0;
         csec_q      <= '0;
         sec_q       <= '0;
         min_q       <= '0;
         hour_q      <= HourRst;
         pm_q        <= 1'b0;
         sec_pulse_q <= 1'b0;
      end else begin
         // Edge detectors keep running through a clear.
         tick_s1_q   <= i_tick_clk;
         tick_s2_q   <= tick_s1_q;
         inc_s1_q    <= i_set_inc;
         inc_s2_q    <= inc_s1_q;
         csec_q      <= csec_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         pm_q        <= pm_d;
         sec_pulse_q <= sec_pulse_d;
      end
   end

   assign o_csec      = csec_q;
   assign o_sec       = sec_q;
   assign o_min       = min_q;
   assign o_hour      = hour_q;
   assign o_pm        = pm_q;
   assign o_sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_time_clock_counter.sv
// Directed self-checking bench for time_clock_counter. Inputs change 1 ns after
// a rising edge and outputs are sampled there too.
module tb_time_clock_counter;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_tick_clk = 1'b0;
   logic       i_run = 1'b0;
   logic       i_clear = 1'b0;
   logic       i_set_en = 1'b0;
   logic [1:0] i_set_sel = 2'd3;
   logic       i_set_inc = 1'b0;
   logic [6:0] o_csec;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   logic       o_pm;
   logic       o_sec_pulse;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;

`ifdef TIME_CLOCK_12H_EN
   localparam int HourRst = 12;
`else
   localparam int HourRst = 0;
`endif

   time_clock_counter dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tick_clk  (i_tick_clk),
      .i_run       (i_run),
      .i_clear     (i_clear),
      .i_set_en    (i_set_en),
      .i_set_sel   (i_set_sel),
      .i_set_inc   (i_set_inc),
      .o_csec      (o_csec),
      .o_sec       (o_sec),
      .o_min       (o_min),
      .o_hour      (o_hour),
      .o_pm        (o_pm),
      .o_sec_pulse (o_sec_pulse)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s,
                             input int cs);
      check({tag, ".hour"}, int'(o_hour), h);
      check({tag, ".min"}, int'(o_min), m);
      check({tag, ".sec"}, int'(o_sec), s);
      check({tag, ".csec"}, int'(o_csec), cs);
   endtask

   // Advance n edges, sampling 1 ns after each and counting seconds pulses.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
         if (o_sec_pulse) pulse_cnt++;
      end
   endtask

   task automatic tick_pulse();
      i_tick_clk = 1'b1;
      cyc(2);
      i_tick_clk = 1'b0;
      cyc(2);
   endtask

   task automatic inc_pulse();
      i_set_inc = 1'b1;
      cyc(2);
      i_set_inc = 1'b0;
      cyc(2);
   endtask

   task automatic set_field(input logic [1:0] sel, input int n);
      i_set_sel = sel;
      repeat (n) inc_pulse();
   endtask

   initial begin
      // Reset state
      cyc(2);
      i_reset = 1'b0;
      check_time("reset", HourRst, 0, 0, 0);
      check("reset.pm", int'(o_pm), 0);
      check("reset.pulse", int'(o_sec_pulse), 0);

      // First tick latency, then 9 more ticks
      i_run = 1'b1;
      i_tick_clk = 1'b1;
      cyc(1);
      check("lat.edge1", int'(o_csec), 0);
      cyc(1);
      check("lat.edge2", int'(o_csec), 1);
      i_tick_clk = 1'b0;
      cyc(2);
      repeat (9) tick_pulse();
      check("run10.csec", int'(o_csec), 10);
      check("run10.sec", int'(o_sec), 0);
      check("run10.pulse", pulse_cnt, 0);

`ifndef TIME_CLOCK_12H_EN
      // Load 23:59:59 via set mode, then 99 ticks, then the day wrap
      i_set_en = 1'b1;
      set_field(2'd2, 23);
      set_field(2'd1, 59);
      set_field(2'd0, 59);
      check_time("load", 23, 59, 59, 0);
      i_set_en = 1'b0;
      repeat (99) tick_pulse();
      check_time("pre_wrap", 23, 59, 59, 99);
      check("pre_wrap.pulse", pulse_cnt, 0);
      tick_pulse();
      check_time("day_wrap", 0, 0, 0, 0);
      check("day_wrap.pulse", pulse_cnt, 1);

      // Run stopped: ticks discarded
      i_run = 1'b0;
      repeat (20) tick_pulse();
      check_time("stopped", 0, 0, 0, 0);
      i_run = 1'b1;
      tick_pulse();
      check_time("resume", 0, 0, 0, 1);

      // Set minutes with wrap and no carry; a held button counts once
      pulse_cnt = 0;
      i_set_en = 1'b1;
      set_field(2'd1, 61);
      check_time("setmin61", 0, 1, 0, 1);
      check("setmin61.pulse", pulse_cnt, 0);
      i_set_inc = 1'b1;
      cyc(50);
      i_set_inc = 1'b0;
      cyc(2);
      check("hold.min", int'(o_min), 2);
      set_field(2'd3, 3);
      check_time("sel3", 0, 2, 0, 1);

      // Clear, then load 05:10:20.30
      i_clear = 1'b1;
      cyc(1);
      i_clear = 1'b0;
      check_time("clear", 0, 0, 0, 0);
      set_field(2'd2, 5);
      set_field(2'd1, 10);
      set_field(2'd0, 20);
      i_set_en = 1'b0;
      repeat (30) tick_pulse();
      check_time("load2", 5, 10, 20, 30);

      // Tick edge, set inc and clear coincide
      i_set_en = 1'b1;
      i_set_sel = 2'd0;
      i_tick_clk = 1'b1;
      i_set_inc = 1'b1;
      cyc(1);
      i_clear = 1'b1;
      cyc(1);
      i_clear = 1'b0;
      check_time("coincide", 0, 0, 0, 0);
      i_tick_clk = 1'b0;
      i_set_inc = 1'b0;
      cyc(2);
      check_time("coincide_after", 0, 0, 0, 0);
      i_set_en = 1'b0;

      // Reset mid-count drops an in-flight tick
      repeat (3) tick_pulse();
      check("precnt.csec", int'(o_csec), 3);
      i_tick_clk = 1'b1;
      cyc(1);
      i_reset = 1'b1;
      i_tick_clk = 1'b0;
      cyc(1);
      check_time("midreset", 0, 0, 0, 0);
      i_reset = 1'b0;
      cyc(3);
      check("midreset_after.csec", int'(o_csec), 0);
`else
      // 12h: 11:59:59.99 AM -> 12:00:00.00 PM
      i_set_en = 1'b1;
      set_field(2'd2, 11);
      set_field(2'd1, 59);
      set_field(2'd0, 59);
      check_time("load12", 11, 59, 59, 0);
      check("load12.pm", int'(o_pm), 0);
      i_set_en = 1'b0;
      repeat (99) tick_pulse();
      tick_pulse();
      check_time("noon", 12, 0, 0, 0);
      check("noon.pm", int'(o_pm), 1);
      i_set_en = 1'b1;
      set_field(2'd2, 1);
      check("set12to1.hour", int'(o_hour), 1);
      check("set12to1.pm", int'(o_pm), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
